// File: rtl/line_buffer.sv
// Line buffer: keeps WIN_SIZE-1 previous rows and emits one column-aligned pixel stack per valid.
// Optional LINE_BUFFER_ZERO_PAD_EN zeroes line_out rows that lie above the top of the frame.
module line_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int WIN_SIZE     = 3,
    parameter int IMAGE_HEIGHT = 480
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sof,
    input  logic                                 pixel_valid,
    input  logic [DATA_WIDTH-1:0]                pixel_in,
    output logic [DATA_WIDTH-1:0]                pixel_out,
    output logic                                 pixel_out_valid,
    output logic [WIN_SIZE-2:0][DATA_WIDTH-1:0]  line_out,
    output logic [((IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1)-1:0]   col_out,
    output logic [((IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1)-1:0] row_out,
    output logic                                 rows_ready,
    output logic                                 eof
);

    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int NL = WIN_SIZE - 1;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          last_col, last_row;

    logic [DATA_WIDTH-1:0] mem [NL][IMAGE_WIDTH];
    logic [NL-1:0][DATA_WIDTH-1:0] line_d;

    // sof overrides the running count so a frame can restart anywhere
    always_comb begin
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        last_col = (cur_col == CW'(IMAGE_WIDTH - 1));
        last_row = (cur_row == RW'(IMAGE_HEIGHT - 1));
        col_d    = last_col ? '0 : cur_col + 1'b1;
        row_d    = cur_row;
        if (last_col) begin
            row_d = last_row ? '0 : cur_row + 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NL; k++) begin
            line_d[k] = mem[k][cur_col];
`ifdef LINE_BUFFER_ZERO_PAD_EN
            if (int'(cur_row) <= k) begin
                line_d[k] = '0;
            end
`endif
        end
    end

    // Vertical cascade: each line memory takes the old word of the one above it
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            mem[0][cur_col] <= pixel_in;
            for (int k = 1; k < NL; k++) begin
                mem[k][cur_col] <= mem[k-1][cur_col];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q           <= '0;
            row_q           <= '0;
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            line_out        <= '0;
            col_out         <= '0;
            row_out         <= '0;
            rows_ready      <= 1'b0;
            eof             <= 1'b0;
        end else begin
            pixel_out_valid <= pixel_valid;
            eof             <= pixel_valid && last_col && last_row;
            rows_ready      <= pixel_valid && (int'(cur_row) >= NL);
            if (pixel_valid) begin
                col_q     <= col_d;
                row_q     <= row_d;
                pixel_out <= pixel_in;
                line_out  <= line_d;
                col_out   <= cur_col;
                row_out   <= cur_row;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Bench for line_buffer: directed frames plus random traffic against a per-column history model.
// Honours LINE_BUFFER_ZERO_PAD_EN the same way as the design.
module tb_line_buffer;

    localparam int DW  = 8;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int WIN = 3;
    localparam int NL  = WIN - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   sof = 1'b0;
    logic                   pixel_valid = 1'b0;
    logic [DW-1:0]          pixel_in = '0;
    logic [DW-1:0]          pixel_out;
    logic                   pixel_out_valid;
    logic [NL-1:0][DW-1:0]  line_out;
    logic [1:0]             col_out;
    logic [1:0]             row_out;
    logic                   rows_ready;
    logic                   eof;

    line_buffer #(
        .DATA_WIDTH  (DW),
        .IMAGE_WIDTH (W),
        .WIN_SIZE    (WIN),
        .IMAGE_HEIGHT(H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sof            (sof),
        .pixel_valid    (pixel_valid),
        .pixel_in       (pixel_in),
        .pixel_out      (pixel_out),
        .pixel_out_valid(pixel_out_valid),
        .line_out       (line_out),
        .col_out        (col_out),
        .row_out        (row_out),
        .rows_ready     (rows_ready),
        .eof            (eof)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: raster position of the next pixel and, per column, the values written there
    int mcol = 0;
    int mrow = 0;
    int hist [W][NL];
    int hlen [W];

    int exp_po, exp_col, exp_row;
    bit exp_v, exp_rr, exp_eof;
    int exp_lo [NL];
    bit exp_lk [NL];

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("valid", int'(pixel_out_valid), int'(exp_v));
        chk("pixel", int'(pixel_out), exp_po);
        chk("col", int'(col_out), exp_col);
        chk("row", int'(row_out), exp_row);
        chk("rows_ready", int'(rows_ready), int'(exp_rr));
        chk("eof", int'(eof), int'(exp_eof));
        for (int k = 0; k < NL; k++) begin
            if (exp_lk[k]) chk($sformatf("line%0d", k), int'(line_out[k]), exp_lo[k]);
        end
    endtask

    task automatic model_reset();
        mcol = 0; mrow = 0;
        exp_po = 0; exp_col = 0; exp_row = 0;
        exp_v = 0; exp_rr = 0; exp_eof = 0;
        for (int k = 0; k < NL; k++) begin
            exp_lo[k] = 0;
            exp_lk[k] = 1;
        end
    endtask

    task automatic step(input bit v, input bit s, input int d);
        int c, r;
        pixel_valid = v;
        sof         = s;
        pixel_in    = DW'(d);
        if (v) begin
            c = s ? 0 : mcol;
            r = s ? 0 : mrow;
            for (int k = 0; k < NL; k++) begin
                exp_lk[k] = (hlen[c] > k);
                exp_lo[k] = exp_lk[k] ? hist[c][k] : 0;
`ifdef LINE_BUFFER_ZERO_PAD_EN
                if (r < k + 1) begin
                    exp_lk[k] = 1;
                    exp_lo[k] = 0;
                end
`endif
            end
            for (int k = NL - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = d;
            if (hlen[c] < NL) hlen[c]++;
            exp_po  = d;
            exp_col = c;
            exp_row = r;
            exp_v   = 1;
            exp_rr  = (r >= NL);
            exp_eof = (r == H - 1) && (c == W - 1);
            mcol = (c + 1) % W;
            mrow = (c == W - 1) ? (r + 1) % H : r;
        end else begin
            exp_v   = 0;
            exp_rr  = 0;
            exp_eof = 0;
        end
        @(posedge clk);
        #1;
        check_all();
        pixel_valid = 0;
        sof         = 0;
    endtask

    initial begin
        for (int c = 0; c < W; c++) hlen[c] = 0;
        model_reset();

        // Reset state
        rst = 1;
        #12;
        check_all();
        @(negedge clk);
        rst = 0;

        // Frame 1: 0..15 contiguous
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, i);
            if (i == 9) begin
                chk("p9_lo0", int'(line_out[0]), 5);
                chk("p9_lo1", int'(line_out[1]), 1);
                chk("p9_col", int'(col_out), 1);
                chk("p9_row", int'(row_out), 2);
                chk("p9_rr", int'(rows_ready), 1);
            end
            if (i == 15) chk("eof_15", int'(eof), 1);
        end

        // Same stream with valid toggling
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, i);
            step(0, 0, 8'hAA);
        end

        // Second frame 100..115
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, 100 + i);
            if (i == 0) begin
                chk("f2_row", int'(row_out), 0);
                chk("f2_rr", int'(rows_ready), 0);
`ifdef LINE_BUFFER_ZERO_PAD_EN
                chk("f2_lo0", int'(line_out[0]), 0);
`else
                chk("f2_lo0", int'(line_out[0]), 12);
`endif
            end
        end

        // Early sof on the 6th pixel
        for (int i = 0; i < 16; i++) begin
            step(1, (i == 0) || (i == 5), 50 + i);
            if (i == 5) begin
                chk("sof6_col", int'(col_out), 0);
                chk("sof6_row", int'(row_out), 0);
            end
        end

        // Random traffic with occasional resync
        for (int i = 0; i < 200; i++) begin
            step(bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 255)));
        end

        // Reset during row 2
        for (int i = 0; i < 10; i++) step(1, i == 0, 200 + i);
        rst = 1;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 0;
        step(1, 0, 77);
        chk("post_rst_col", int'(col_out), 0);
        chk("post_rst_row", int'(row_out), 0);
        for (int i = 0; i < 20; i++) step(1, 0, 80 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
